// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   SIZE_*      : request size encodings (reqSize)
//   lsu_state_t : controller state encoding
//   is_misaligned() : alignment / legality check on a request
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } lsu_state_t;

    // Half needs addr[0]==0, word needs addr[1:0]==00, size 11 is never legal.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane logic.
//   word       : 32-bit memory word (byte offset 0 in bits [31:24])
//   offset     : byte offset within the word
//   size       : access size (SIZE_BYTE / SIZE_HALF / SIZE_WORD)
//   sign_ext   : sign-extend sub-word loads when 1
//   store_data : right-justified store data
//   load_data  : extracted, extended load result
//   merge_data : word with the store lane replaced, other lanes unchanged
module mem_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  shift;
    logic [31:0] lane;
    logic [31:0] mask;

    always_comb begin
        shift      = 5'd0;
        mask       = 32'hFFFF_FFFF;
        load_data  = word;
        // Big-endian: byte offset o sits (3-o) bytes above bit 0, half offset
        // 0 sits 16 bits up and half offset 2 sits at bit 0.
        case (size)
            SIZE_BYTE: begin
                shift = {~offset, 3'b000};
                mask  = 32'h0000_00FF << shift;
            end
            SIZE_HALF: begin
                shift = {~offset[1], 4'b0000};
                mask  = 32'h0000_FFFF << shift;
            end
            default: begin
                shift = 5'd0;
                mask  = 32'hFFFF_FFFF;
            end
        endcase
        lane = word >> shift;
        case (size)
            SIZE_BYTE: load_data = {{24{lane[7] & sign_ext}}, lane[7:0]};
            SIZE_HALF: load_data = {{16{lane[15] & sign_ext}}, lane[15:0]};
            default:   load_data = word;
        endcase
        merge_data = (word & ~mask) | ((store_data << shift) & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a single-cycle,
// big-endian, word-wide memory.
//   clk, rst            : clock, synchronous active-high reset
//   reqValid/reqReady   : request handshake (ready only in IDLE)
//   reqWrite/reqSize/reqSigned/reqAddr/reqWData : request fields
//   respValid/respRData/respErr : one-cycle completion with load data / error
//   memAddress/memWriteData/memWriteEnable/memReadData : memory port
// Sub-word stores are read-modify-write: READ captures the word and merges
// the new lane, WRITE commits it.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [1:0]            reqSize,
    input  logic                  reqSigned,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [31:0]           reqWData,
    output logic                  respValid,
    output logic [31:0]           respRData,
    output logic                  respErr,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [31:0]           memWriteData,
    output logic                  memWriteEnable,
    input  logic [31:0]           memReadData
);

    lsu_state_t  state, state_next;
    logic        accept;
    logic        misaligned;
    logic        op_write;
    logic [1:0]  op_size;
    logic        op_signed;
    logic [1:0]  op_offset;
    logic [31:0] op_wdata;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept     = reqValid && reqReady;
    assign misaligned = is_misaligned(reqSize, reqAddr[1:0]);

    mem_lane_align u_align (
        .word       (memReadData),
        .offset     (op_offset),
        .size       (op_size),
        .sign_ext   (op_signed),
        .store_data (op_wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        reqReady       = 1'b0;
        respValid      = 1'b0;
        memWriteEnable = 1'b0;
        case (state)
            IDLE: begin
                reqReady = 1'b1;
                if (accept) begin
                    if (misaligned)
                        state_next = RESP;
                    else if (reqWrite && reqSize == SIZE_WORD)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:    state_next = op_write ? WRITE : RESP;
            WRITE: begin
                memWriteEnable = 1'b1;
                state_next     = RESP;
            end
            RESP: begin
                respValid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_write     <= 1'b0;
            op_size      <= SIZE_BYTE;
            op_signed    <= 1'b0;
            op_offset    <= 2'b00;
            op_wdata     <= 32'd0;
            memAddress   <= '0;
            memWriteData <= 32'd0;
            respRData    <= 32'd0;
            respErr      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_write   <= reqWrite;
                        op_size    <= reqSize;
                        op_signed  <= reqSigned;
                        op_offset  <= reqAddr[1:0];
                        op_wdata   <= reqWData;
                        memAddress <= {reqAddr[ADDR_WIDTH-1:2], 2'b00};
                        respErr    <= misaligned;
                        respRData  <= 32'd0;
                        // Word stores go straight to WRITE; sub-word stores
                        // overwrite this with the merged word in READ.
                        if (reqWrite)
                            memWriteData <= reqWData;
                    end
                end
                READ: begin
                    if (op_write)
                        memWriteData <= merge_data;
                    else
                        respRData <= load_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;
    logic        respValid;
    logic [31:0] respRData;
    logic        respErr;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWriteEnable;
    logic [31:0] memReadData;

    logic [31:0] mem [0:255];
    logic        tb_we;
    logic [7:0]  tb_idx;
    logic [31:0] tb_data;
    int          we_count;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqWrite       (reqWrite),
        .reqSize        (reqSize),
        .reqSigned      (reqSigned),
        .reqAddr        (reqAddr),
        .reqWData       (reqWData),
        .respValid      (respValid),
        .respRData      (respRData),
        .respErr        (respErr),
        .memAddress     (memAddress),
        .memWriteData   (memWriteData),
        .memWriteEnable (memWriteEnable),
        .memReadData    (memReadData)
    );

    // Memory model: combinational read, write on rising edge.
    assign memReadData = mem[memAddress[9:2]];

    always @(posedge clk) begin
        if (memWriteEnable) begin
            mem[memAddress[9:2]] <= memWriteData;
            we_count     <= we_count + 1;
            last_wr_addr <= memAddress;
            last_wr_data <= memWriteData;
        end else if (tb_we) begin
            mem[tb_idx] <= tb_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_idx  = addr[9:2];
        tb_data = data;
        @(posedge clk);
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Issue one request; lat = negedges after the accept edge until respValid.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
        int guard;
        guard = 0;
        lat = 0;
        rd  = 32'hXXXX_XXXX;
        er  = 1'bx;
        @(negedge clk);
        while (!reqReady && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        reqValid  = 1'b1;
        reqWrite  = w;
        reqSize   = sz;
        reqSigned = sg;
        reqAddr   = a;
        reqWData  = wd;
        @(posedge clk);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) reqValid = 1'b0;
            if (respValid) begin
                lat = i;
                rd  = respRData;
                er  = respErr;
                break;
            end
        end
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          we_before;

    initial begin
        rst       = 1'b1;
        reqValid  = 1'b0;
        reqWrite  = 1'b0;
        reqSize   = SIZE_WORD;
        reqSigned = 1'b0;
        reqAddr   = 32'd0;
        reqWData  = 32'd0;
        tb_we     = 1'b0;
        tb_idx    = 8'd0;
        tb_data   = 32'd0;
        we_count  = 0;
        last_wr_addr = 32'd0;
        last_wr_data = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_reqReady",  {31'd0, reqReady}, 32'd1);
        check("rst_respValid", {31'd0, respValid}, 32'd0);
        check("rst_respErr",   {31'd0, respErr}, 32'd0);
        check("rst_respRData", respRData, 32'd0);
        check("rst_memWE",     {31'd0, memWriteEnable}, 32'd0);
        check("rst_memAddr",   memAddress, 32'd0);
        check("rst_memWData",  memWriteData, 32'd0);
        rst = 1'b0;

        preload(32'h100, 32'h80FF_1234);
        preload(32'h108, 32'h1122_3344);

        // lb signed at 0x101 -> byte 0xFF sign-extended
        do_req(1'b0, SIZE_BYTE, 1'b1, 32'h101, 32'd0, lat, rd, er);
        check("lb_data", rd, 32'hFFFF_FFFF);
        check("lb_lat",  lat, 32'd2);
        check("lb_err",  {31'd0, er}, 32'd0);

        // lbu at 0x101 -> zero-extended
        do_req(1'b0, SIZE_BYTE, 1'b0, 32'h101, 32'd0, lat, rd, er);
        check("lbu_data", rd, 32'h0000_00FF);

        // lhu at 0x102 -> low half
        do_req(1'b0, SIZE_HALF, 1'b0, 32'h102, 32'd0, lat, rd, er);
        check("lhu_data", rd, 32'h0000_1234);

        // lh at 0x100 -> high half sign-extended
        do_req(1'b0, SIZE_HALF, 1'b1, 32'h100, 32'd0, lat, rd, er);
        check("lh_data", rd, 32'hFFFF_80FF);
        check("lh_lat",  lat, 32'd2);

        // lw signed flag ignored for word loads
        do_req(1'b0, SIZE_WORD, 1'b1, 32'h100, 32'd0, lat, rd, er);
        check("lw_signed_ignored", rd, 32'h80FF_1234);

        // sb 0xAB at 0x102 -> read-modify-write
        we_before = we_count;
        do_req(1'b1, SIZE_BYTE, 1'b1, 32'h102, 32'h0000_00AB, lat, rd, er);
        check("sb_lat",     lat, 32'd3);
        check("sb_we_cnt",  we_count - we_before, 32'd1);
        check("sb_wr_addr", last_wr_addr, 32'h100);
        check("sb_wr_data", last_wr_data, 32'h80FF_AB34);
        check("sb_mem",     mem[8'h40], 32'h80FF_AB34);
        check("sb_rdata",   rd, 32'd0);
        check("sb_err",     {31'd0, er}, 32'd0);

        // sh 0xCAFE at 0x100 -> upper half replaced
        do_req(1'b1, SIZE_HALF, 1'b0, 32'h100, 32'h1234_CAFE, lat, rd, er);
        check("sh_mem", mem[8'h40], 32'hCAFE_AB34);

        // sw at 0x104 then lw back
        we_before = we_count;
        do_req(1'b1, SIZE_WORD, 1'b0, 32'h104, 32'hDEAD_BEEF, lat, rd, er);
        check("sw_lat",     lat, 32'd2);
        check("sw_we_cnt",  we_count - we_before, 32'd1);
        check("sw_wr_data", last_wr_data, 32'hDEAD_BEEF);
        check("sw_wr_addr", last_wr_addr, 32'h104);
        do_req(1'b0, SIZE_WORD, 1'b0, 32'h104, 32'd0, lat, rd, er);
        check("lw_data", rd, 32'hDEAD_BEEF);

        // Misaligned and illegal requests
        we_before = we_count;
        do_req(1'b0, SIZE_WORD, 1'b0, 32'h103, 32'd0, lat, rd, er);
        check("lw_mis_err",   {31'd0, er}, 32'd1);
        check("lw_mis_lat",   lat, 32'd1);
        check("lw_mis_rdata", rd, 32'd0);
        do_req(1'b1, SIZE_HALF, 1'b0, 32'h101, 32'h0000_5555, lat, rd, er);
        check("sh_mis_err", {31'd0, er}, 32'd1);
        check("sh_mis_lat", lat, 32'd1);
        do_req(1'b0, SIZE_ILL, 1'b0, 32'h100, 32'd0, lat, rd, er);
        check("ill_err", {31'd0, er}, 32'd1);
        check("mis_we_cnt", we_count - we_before, 32'd0);
        check("mis_mem", mem[8'h40], 32'hCAFE_AB34);

        // Reset during the READ of a sub-word store
        we_before = we_count;
        @(negedge clk);
        reqValid  = 1'b1;
        reqWrite  = 1'b1;
        reqSize   = SIZE_BYTE;
        reqSigned = 1'b0;
        reqAddr   = 32'h108;
        reqWData  = 32'h0000_0077;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        check("rstmid_read_we", {31'd0, memWriteEnable}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_we",       {31'd0, memWriteEnable}, 32'd0);
        check("rstmid_reqReady", {31'd0, reqReady}, 32'd1);
        check("rstmid_memAddr",  memAddress, 32'd0);
        repeat (4) @(negedge clk);
        check("rstmid_we_cnt",   we_count - we_before, 32'd0);
        check("rstmid_mem",      mem[8'h42], 32'h1122_3344);
        check("rstmid_respValid", {31'd0, respValid}, 32'd0);
        check("rstmid_ready2",   {31'd0, reqReady}, 32'd1);

        // Unit still works after the abandoned operation
        do_req(1'b0, SIZE_BYTE, 1'b0, 32'h10B, 32'd0, lat, rd, er);
        check("post_rst_lbu", rd, 32'h0000_0044);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
